// File: rtl/window_frame_seq.sv
// Frame-windowing sequencer: walks FRAME_LEN samples through read/multiply/write, then zero-pads to FFT_LEN.
// Optional WIN_SYMM_COEF_EN folds coef_addr onto a half-length symmetric window ROM.
module window_frame_seq #(
    parameter int FRAME_LEN  = 400,
    parameter int FFT_LEN    = 512,
    parameter int HOP        = 160,
    parameter int BUF_DEPTH  = 1024,
    parameter int MUL_CYCLES = 10,
    localparam int BUF_AW    = $clog2(BUF_DEPTH),
`ifdef WIN_SYMM_COEF_EN
    localparam int COEF_LEN  = (FRAME_LEN + 1) / 2,
`else
    localparam int COEF_LEN  = FRAME_LEN,
`endif
    localparam int COEF_AW   = (COEF_LEN > 1) ? $clog2(COEF_LEN) : 1,
    localparam int FFT_AW    = $clog2(FFT_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    output logic [BUF_AW-1:0]  rd_addr,
    output logic [COEF_AW-1:0] coef_addr,
    output logic [FFT_AW-1:0]  wr_addr,
    output logic               mul_en,
    output logic               wr_en,
    output logic               fill_zero,
    output logic               busy,
    output logic               frame_done
);

    localparam int N_W  = $clog2(FRAME_LEN);
    localparam int MC_W = $clog2(MUL_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CAL, S_READ, S_MUL, S_WRITE, S_ZCAL, S_ZWRITE, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [N_W-1:0]     n, n_nxt;
    logic [FFT_AW-1:0]  z, z_nxt;
    logic [BUF_AW-1:0]  base, base_nxt;
    logic [MC_W-1:0]    mcnt, mcnt_nxt;

    logic [BUF_AW-1:0]  rd_nxt;
    logic [COEF_AW-1:0] coef_nxt;
    logic [FFT_AW-1:0]  wr_nxt;
    logic               mul_nxt, wren_nxt, fz_nxt, busy_nxt, done_nxt;

    // One-bit-wider add with a single conditional subtract; both operands are below BUF_DEPTH.
    function automatic logic [BUF_AW-1:0] wrap_add(input logic [BUF_AW-1:0] a,
                                                   input logic [BUF_AW:0]   b);
        logic [BUF_AW:0] sum;
        sum = {1'b0, a} + b;
        if (sum >= (BUF_AW+1)'(BUF_DEPTH)) sum = sum - (BUF_AW+1)'(BUF_DEPTH);
        return sum[BUF_AW-1:0];
    endfunction

    function automatic logic [COEF_AW-1:0] coef_of(input logic [N_W-1:0] idx);
`ifdef WIN_SYMM_COEF_EN
        int ni;
        ni = int'(idx);
        if (ni < COEF_LEN) return COEF_AW'(ni);
        else               return COEF_AW'(FRAME_LEN - 1 - ni);
`else
        return COEF_AW'(idx);
`endif
    endfunction

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        z_nxt     = z;
        base_nxt  = base;
        mcnt_nxt  = mcnt;

        case (state)
            S_IDLE:  if (start) state_nxt = S_CAL;
            S_CAL:   state_nxt = S_READ;
            S_READ: begin
                state_nxt = S_MUL;
                mcnt_nxt  = MC_W'(MUL_CYCLES - 1);
            end
            S_MUL: begin
                if (mcnt == '0) state_nxt = S_WRITE;
                else            mcnt_nxt  = mcnt - MC_W'(1);
            end
            S_WRITE: begin
                if (n != N_W'(FRAME_LEN - 1)) begin
                    state_nxt = S_CAL;
                    n_nxt     = n + N_W'(1);
                end else if (FFT_LEN > FRAME_LEN) begin
                    state_nxt = S_ZCAL;
                    z_nxt     = FFT_AW'(FRAME_LEN);
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_ZCAL:  state_nxt = S_ZWRITE;
            S_ZWRITE: begin
                if (z == FFT_AW'(FFT_LEN - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ZCAL;
                    z_nxt     = z + FFT_AW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                base_nxt  = wrap_add(base, (BUF_AW+1)'(HOP));
                n_nxt     = '0;
                z_nxt     = '0;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (flush) begin
            state_nxt = S_IDLE;
            n_nxt     = '0;
            z_nxt     = '0;
            base_nxt  = '0;
            mcnt_nxt  = '0;
        end

        // Outputs are decoded from the next state so the registered copy lines up with the state.
        busy_nxt = (state_nxt != S_IDLE);
        mul_nxt  = (state_nxt == S_MUL);
        wren_nxt = (state_nxt == S_WRITE) || (state_nxt == S_ZWRITE);
        fz_nxt   = (state_nxt == S_ZCAL) || (state_nxt == S_ZWRITE);
        done_nxt = (state_nxt == S_DONE);

        rd_nxt   = rd_addr;
        coef_nxt = coef_addr;
        wr_nxt   = wr_addr;
        if (state_nxt == S_CAL) begin
            rd_nxt   = wrap_add(base_nxt, (BUF_AW+1)'(n_nxt));
            coef_nxt = coef_of(n_nxt);
        end
        if (state_nxt == S_WRITE) wr_nxt = FFT_AW'(n_nxt);
        if (state_nxt == S_ZCAL)  wr_nxt = z_nxt;
        if (flush) begin
            rd_nxt   = '0;
            coef_nxt = '0;
            wr_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n          <= '0;
            z          <= '0;
            base       <= '0;
            mcnt       <= '0;
            rd_addr    <= '0;
            coef_addr  <= '0;
            wr_addr    <= '0;
            mul_en     <= 1'b0;
            wr_en      <= 1'b0;
            fill_zero  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            n          <= n_nxt;
            z          <= z_nxt;
            base       <= base_nxt;
            mcnt       <= mcnt_nxt;
            rd_addr    <= rd_nxt;
            coef_addr  <= coef_nxt;
            wr_addr    <= wr_nxt;
            mul_en     <= mul_nxt;
            wr_en      <= wren_nxt;
            fill_zero  <= fz_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_window_frame_seq.sv
// Bench for window_frame_seq: three instances (zero-padded, no padding, odd frame length) checked
// against a per-frame expected write list and cycle count derived from the frame rules.
module tb_window_frame_seq;

    localparam int HOP_P   = 2;
    localparam int DEPTH_P = 6;
    localparam int MC_P    = 2;
`ifdef WIN_SYMM_COEF_EN
    localparam int CW_A = 1, CW_B = 1, CW_C = 2;
`else
    localparam int CW_A = 2, CW_B = 2, CW_C = 3;
`endif

    logic clk, rst_n;
    logic [2:0] start_v, flush_v;

    logic [2:0]      rd_a, rd_b, rd_c;
    logic [CW_A-1:0] coef_a;
    logic [CW_B-1:0] coef_b;
    logic [CW_C-1:0] coef_c;
    logic [2:0]      wr_a, wr_c;
    logic [1:0]      wr_b;
    logic [2:0]      mul_w, wren_w, fz_w, busy_w, done_w;

    logic [7:0] rd_m[3], coef_m[3], wr_m[3];

    int fl_p[3]  = '{4, 4, 5};
    int ffl_p[3] = '{8, 4, 8};
    int base_m[3];
    int n_checks, n_pass;

    window_frame_seq #(.FRAME_LEN(4), .FFT_LEN(8), .HOP(HOP_P), .BUF_DEPTH(DEPTH_P), .MUL_CYCLES(MC_P)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .flush(flush_v[0]),
        .rd_addr(rd_a), .coef_addr(coef_a), .wr_addr(wr_a), .mul_en(mul_w[0]), .wr_en(wren_w[0]),
        .fill_zero(fz_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

    window_frame_seq #(.FRAME_LEN(4), .FFT_LEN(4), .HOP(HOP_P), .BUF_DEPTH(DEPTH_P), .MUL_CYCLES(MC_P)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .flush(flush_v[1]),
        .rd_addr(rd_b), .coef_addr(coef_b), .wr_addr(wr_b), .mul_en(mul_w[1]), .wr_en(wren_w[1]),
        .fill_zero(fz_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

    window_frame_seq #(.FRAME_LEN(5), .FFT_LEN(8), .HOP(HOP_P), .BUF_DEPTH(DEPTH_P), .MUL_CYCLES(MC_P)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .flush(flush_v[2]),
        .rd_addr(rd_c), .coef_addr(coef_c), .wr_addr(wr_c), .mul_en(mul_w[2]), .wr_en(wren_w[2]),
        .fill_zero(fz_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

    assign rd_m[0]   = 8'(rd_a);
    assign rd_m[1]   = 8'(rd_b);
    assign rd_m[2]   = 8'(rd_c);
    assign coef_m[0] = 8'(coef_a);
    assign coef_m[1] = 8'(coef_b);
    assign coef_m[2] = 8'(coef_c);
    assign wr_m[0]   = 8'(wr_a);
    assign wr_m[1]   = 8'(wr_b);
    assign wr_m[2]   = 8'(wr_c);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] out_all(input int i);
        return {3'b0, rd_m[i], coef_m[i], wr_m[i], mul_w[i], wren_w[i], fz_w[i], busy_w[i], done_w[i]};
    endfunction

    function automatic int exp_coef(input int i, input int nn);
`ifdef WIN_SYMM_COEF_EN
        return (nn < (fl_p[i] + 1) / 2) ? nn : fl_p[i] - 1 - nn;
`else
        return nn + 0 * i;
`endif
    endfunction

    function automatic int exp_cycles(input int i);
        return fl_p[i] * (3 + MC_P) + (ffl_p[i] - fl_p[i]) * 2 + 1;
    endfunction

    // Runs one frame on instance i; inj>0 re-pulses start on that cycle (must be ignored).
    task automatic run_frame(input int i, input int inj);
        logic [31:0] exp_q[$];
        logic [31:0] obs;
        int c, mul_run, bad_busy;
        bit done_seen;
        for (int nn = 0; nn < fl_p[i]; nn++)
            exp_q.push_back({8'd0, 8'(nn), 8'((base_m[i] + nn) % DEPTH_P), 8'(exp_coef(i, nn))});
        for (int zz = fl_p[i]; zz < ffl_p[i]; zz++)
            exp_q.push_back({8'd1, 8'(zz), 8'd0, 8'd0});
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_v[i] = 1'b1;
        c = 0; mul_run = 0; bad_busy = 0; done_seen = 0;
        while (!done_seen && c < 300) begin
            @(negedge clk);
            c++;
            start_v[i] = (c == inj);
            if (!busy_w[i]) bad_busy++;
            if (mul_w[i]) mul_run++;
            if (wren_w[i]) begin
                obs = {7'd0, fz_w[i], wr_m[i], fz_w[i] ? 8'd0 : rd_m[i], fz_w[i] ? 8'd0 : coef_m[i]};
                if (!fz_w[i]) check_eq("mul_len", 32'(mul_run), 32'(MC_P));
                mul_run = 0;
                if (exp_q.size() == 0) check_eq("extra_write", obs, 32'hFFFF_FFFF);
                else check_eq("write", obs, exp_q.pop_front());
            end
            if (done_w[i]) begin
                done_seen = 1;
                check_eq("done_cycle", 32'(c), 32'(exp_cycles(i)));
            end
        end
        if (!done_seen) check_eq("done_timeout", 32'd0, 32'd1);
        check_eq("busy_frame", 32'(bad_busy), 32'd0);
        check_eq("writes_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        start_v[i] = 1'b0;
        check_eq("idle_after", {28'd0, busy_w[i], done_w[i], mul_w[i], wren_w[i]}, 32'd0);
        base_m[i] = (base_m[i] + HOP_P) % DEPTH_P;
    endtask

    // Starts a frame and asserts flush together with start on cycle fc.
    task automatic flush_frame(input int i, input int fc);
        @(negedge clk);
        start_v[i] = 1'b1;
        for (int c = 1; c <= fc; c++) begin
            @(negedge clk);
            start_v[i] = (c == fc);
            flush_v[i] = (c == fc);
        end
        @(negedge clk);
        start_v[i] = 1'b0;
        flush_v[i] = 1'b0;
        check_eq("flush_outputs", out_all(i), 32'd0);
        @(negedge clk);
        check_eq("flush_stays_idle", {31'd0, busy_w[i]}, 32'd0);
        base_m[i] = 0;
    endtask

    task automatic reset_mid(input int i, input int rc);
        @(negedge clk);
        start_v[i] = 1'b1;
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            start_v[i] = 1'b0;
        end
        check_eq("pre_reset_mul", {31'd0, mul_w[i]}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset", out_all(i), 32'd0);
        for (int k = 0; k < 3; k++) base_m[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int i, pick;
        n_checks = 0; n_pass = 0;
        start_v = '0; flush_v = '0;
        for (int k = 0; k < 3; k++) base_m[k] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_eq("reset_state", out_all(k), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 0);                      // base 0
        run_frame(0, 0);                      // base 2
        run_frame(0, 0);                      // base 4, read address wraps
        run_frame(1, 0);                      // no zero padding
        run_frame(2, 0);                      // odd frame length coefficient order
        run_frame(0, 3);                      // start re-pulsed during MUL
        flush_frame(0, $urandom_range(21, 28));
        run_frame(0, 0);
        reset_mid(0, 3);
        run_frame(0, 0);

        for (int it = 0; it < 24; it++) begin
            i = $urandom_range(0, 2);
            pick = $urandom_range(0, 3);
            if (pick == 0) flush_frame(i, $urandom_range(1, exp_cycles(i)));
            else run_frame(i, (pick == 1) ? $urandom_range(1, exp_cycles(i)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
